// File: rtl/lift_pkg.sv
// Shared types and defaults for the lift call scheduler.
package lift_pkg;

    localparam int LIFT_N_FLOORS = 8;
    localparam int LIFT_FLOOR_W  = $clog2(LIFT_N_FLOORS);

    // Sweep direction encoding
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OFFER  = 2'd1,
        ST_TRAVEL = 2'd2,
        ST_CLEAR  = 2'd3
    } lift_state_e;

endpackage

// File: rtl/lift_target_sel.sv
// Collective (SCAN) target search over the pending call sets.
// Purely combinational: picks the next floor and the direction the car
// will be sweeping when it gets there.
module lift_target_sel
    import lift_pkg::*;
#(
    parameter int N_FLOORS = LIFT_N_FLOORS,
    parameter int FLOOR_W  = LIFT_FLOOR_W
) (
    input  logic [N_FLOORS-1:0] pend_up_i,
    input  logic [N_FLOORS-1:0] pend_dn_i,
    input  logic [N_FLOORS-1:0] pend_car_i,
    input  logic [FLOOR_W-1:0]  car_floor_i,
    input  logic                dir_up_i,
    output logic                found_o,
    output logic [FLOOR_W-1:0]  floor_o,
    output logic                dir_up_o
);

    logic [N_FLOORS-1:0] a_calls;
    logic [N_FLOORS-1:0] d_calls;
    logic [N_FLOORS-1:0] any_calls;
    int                  cf;

    // Calls at the car's own floor are included in the "nearest" searches
    // so that a matching call there reopens the door instead of being skipped.
    always_comb begin
        a_calls   = pend_up_i | pend_car_i;
        d_calls   = pend_dn_i | pend_car_i;
        any_calls = a_calls | d_calls;
        cf        = int'(car_floor_i);
        found_o   = 1'b0;
        floor_o   = '0;
        dir_up_o  = dir_up_i;
        if (dir_up_i) begin
            // nearest at/above in A: descending scan, last hit is the lowest
            for (int f = N_FLOORS-1; f >= 0; f--)
                if (f >= cf && a_calls[f]) begin found_o = 1'b1; floor_o = FLOOR_W'(f); end
            // otherwise run out to the highest call above
            if (!found_o)
                for (int f = 0; f < N_FLOORS; f++)
                    if (f > cf && any_calls[f]) begin found_o = 1'b1; floor_o = FLOOR_W'(f); end
            // nothing above: reverse, nearest at/below in D
            if (!found_o)
                for (int f = 0; f < N_FLOORS; f++)
                    if (f <= cf && d_calls[f]) begin found_o = 1'b1; floor_o = FLOOR_W'(f); dir_up_o = DIR_DN; end
            if (!found_o)
                for (int f = N_FLOORS-1; f >= 0; f--)
                    if (f < cf && any_calls[f]) begin found_o = 1'b1; floor_o = FLOOR_W'(f); dir_up_o = DIR_DN; end
        end else begin
            // nearest at/below in D: ascending scan, last hit is the highest
            for (int f = 0; f < N_FLOORS; f++)
                if (f <= cf && d_calls[f]) begin found_o = 1'b1; floor_o = FLOOR_W'(f); end
            // otherwise run out to the lowest call below
            if (!found_o)
                for (int f = N_FLOORS-1; f >= 0; f--)
                    if (f < cf && any_calls[f]) begin found_o = 1'b1; floor_o = FLOOR_W'(f); end
            // nothing below: reverse, nearest at/above in A
            if (!found_o)
                for (int f = N_FLOORS-1; f >= 0; f--)
                    if (f >= cf && a_calls[f]) begin found_o = 1'b1; floor_o = FLOOR_W'(f); dir_up_o = DIR_UP; end
            if (!found_o)
                for (int f = 0; f < N_FLOORS; f++)
                    if (f > cf && any_calls[f]) begin found_o = 1'b1; floor_o = FLOOR_W'(f); dir_up_o = DIR_UP; end
        end
    end

endmodule

// File: rtl/lift_call_scheduler.sv
// Lift call scheduler: latches hall/car calls, offers SCAN targets to the car
// over valid/ready and clears served calls when the car arrives.
module lift_call_scheduler
    import lift_pkg::*;
#(
    parameter int N_FLOORS = LIFT_N_FLOORS,
    parameter int FLOOR_W  = LIFT_FLOOR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_FLOORS-1:0] hall_up_i,
    input  logic [N_FLOORS-1:0] hall_dn_i,
    input  logic [N_FLOORS-1:0] car_call_i,
    input  logic [FLOOR_W-1:0]  car_floor_i,
    input  logic                arrive_i,
    output logic                tgt_valid_o,
    output logic [FLOOR_W-1:0]  tgt_floor_o,
    input  logic                tgt_ready_i,
    output logic                dir_up_o,
    output logic [N_FLOORS-1:0] pend_up_o,
    output logic [N_FLOORS-1:0] pend_dn_o,
    output logic [N_FLOORS-1:0] pend_car_o
);

    // Top floor has no up button, ground floor has no down button.
    localparam logic [N_FLOORS-1:0] UP_OK = {1'b0, {(N_FLOORS-1){1'b1}}};
    localparam logic [N_FLOORS-1:0] DN_OK = {{(N_FLOORS-1){1'b1}}, 1'b0};

    lift_state_e         state_q, state_d;
    logic [N_FLOORS-1:0] pend_up_q, pend_up_d;
    logic [N_FLOORS-1:0] pend_dn_q, pend_dn_d;
    logic [N_FLOORS-1:0] pend_car_q, pend_car_d;
    logic [FLOOR_W-1:0]  tgt_q, tgt_d;
    logic                dir_up_q, dir_up_d;

    logic [N_FLOORS-1:0] any_q;
    logic [N_FLOORS-1:0] clr_up, clr_dn, clr_car;
    logic                beyond;
    logic                flip;

    logic                sel_found;
    logic [FLOOR_W-1:0]  sel_floor;
    logic                sel_dir;

    // Served-call masks for the CLEAR cycle; zero in every other state so the
    // selector sees plain registered calls outside CLEAR.
    always_comb begin
        any_q   = pend_up_q | pend_dn_q | pend_car_q;
        clr_up  = '0;
        clr_dn  = '0;
        clr_car = '0;
        beyond  = 1'b0;
        flip    = 1'b0;
        if (state_q == ST_CLEAR) begin
            for (int f = 0; f < N_FLOORS; f++)
                if (any_q[f] && (dir_up_q ? (f > int'(tgt_q)) : (f < int'(tgt_q))))
                    beyond = 1'b1;
            // end of sweep: the waiting passengers at this floor go the other way
            flip           = !beyond;
            clr_car[tgt_q] = 1'b1;
            if (dir_up_q || flip)  clr_up[tgt_q] = 1'b1;
            if (!dir_up_q || flip) clr_dn[tgt_q] = 1'b1;
        end
    end

    lift_target_sel #(
        .N_FLOORS (N_FLOORS),
        .FLOOR_W  (FLOOR_W)
    ) u_sel (
        .pend_up_i   (pend_up_q & ~clr_up),
        .pend_dn_i   (pend_dn_q & ~clr_dn),
        .pend_car_i  (pend_car_q & ~clr_car),
        .car_floor_i (car_floor_i),
        .dir_up_i    (dir_up_q ^ flip),
        .found_o     (sel_found),
        .floor_o     (sel_floor),
        .dir_up_o    (sel_dir)
    );

    // Next-state, pending-call update and target latch.
    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        dir_up_d   = dir_up_q;
        // clear wins over a same-cycle press of the served button
        pend_up_d  = (pend_up_q  | (hall_up_i & UP_OK)) & ~clr_up;
        pend_dn_d  = (pend_dn_q  | (hall_dn_i & DN_OK)) & ~clr_dn;
        pend_car_d = (pend_car_q | car_call_i)          & ~clr_car;
        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    tgt_d    = sel_floor;
                    dir_up_d = sel_dir;
                    state_d  = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (tgt_ready_i) state_d = ST_TRAVEL;
            end
            ST_TRAVEL: begin
                if (arrive_i) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                dir_up_d = dir_up_q ^ flip;
                if (sel_found) begin
                    tgt_d    = sel_floor;
                    dir_up_d = sel_dir;
                    state_d  = ST_OFFER;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and pending-call registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pend_up_q  <= '0;
            pend_dn_q  <= '0;
            pend_car_q <= '0;
            tgt_q      <= '0;
            dir_up_q   <= DIR_UP;
        end else begin
            state_q    <= state_d;
            pend_up_q  <= pend_up_d;
            pend_dn_q  <= pend_dn_d;
            pend_car_q <= pend_car_d;
            tgt_q      <= tgt_d;
            dir_up_q   <= dir_up_d;
        end
    end

    assign tgt_valid_o = (state_q == ST_OFFER);
    assign tgt_floor_o = tgt_q;
    assign dir_up_o    = dir_up_q;
    assign pend_up_o   = pend_up_q;
    assign pend_dn_o   = pend_dn_q;
    assign pend_car_o  = pend_car_q;

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Randomized and directed bench for lift_call_scheduler against a
// floor-distance reference model of the SCAN scheduling rules.
module tb_lift_call_scheduler;

    localparam int NF = 8;

    logic          clk;
    logic [NF-1:0] up_v, dn_v, car_v;
    logic [2:0]    cf_v;
    logic          arr_v, rdy_v, rst_v;

    logic          tgt_valid_o;
    logic [2:0]    tgt_floor_o;
    logic          dir_up_o;
    logic [NF-1:0] pend_up_o, pend_dn_o, pend_car_o;

    lift_call_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_v),
        .hall_up_i   (up_v),
        .hall_dn_i   (dn_v),
        .car_call_i  (car_v),
        .car_floor_i (cf_v),
        .arrive_i    (arr_v),
        .tgt_valid_o (tgt_valid_o),
        .tgt_floor_o (tgt_floor_o),
        .tgt_ready_i (rdy_v),
        .dir_up_o    (dir_up_o),
        .pend_up_o   (pend_up_o),
        .pend_dn_o   (pend_dn_o),
        .pend_car_o  (pend_car_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // model: 0 idle, 1 offering, 2 travelling, 3 clearing
    logic [NF-1:0] m_up, m_dn, m_car;
    int            m_st, m_tgt;
    bit            m_dir;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // SCAN pick by walking outward from the car: first the sweep direction,
    // then the reverse direction.
    task automatic m_sel(input logic [NF-1:0] u, input logic [NF-1:0] d, input logic [NF-1:0] c,
                         input int cf, input bit up, output bit ok, output int fl, output bit nd);
        logic [NF-1:0] a, dd, an;
        a = u | c; dd = d | c; an = a | dd;
        ok = 0; fl = 0; nd = up;
        for (int pass = 0; pass < 2 && !ok; pass++) begin
            bit goup;
            goup = (pass == 0) ? up : !up;
            if (goup) begin
                for (int k = 0; cf + k < NF && !ok; k++) if (a[cf+k]) begin ok = 1; fl = cf + k; end
                for (int g = NF-1; g > cf && !ok; g--) if (an[g]) begin ok = 1; fl = g; end
            end else begin
                for (int k = 0; cf - k >= 0 && !ok; k++) if (dd[cf-k]) begin ok = 1; fl = cf - k; end
                for (int g = 0; g < cf && !ok; g++) if (an[g]) begin ok = 1; fl = g; end
            end
            if (ok) nd = goup;
        end
    endtask

    // One clock: advance the model with the driven inputs, compare, drop pulses.
    task automatic tick();
        logic [NF-1:0] nu, nd, nc, ku, kd, kc, an;
        int nst, ntgt, fl;
        bit ndir, ok, sd, beyond;
        ku = '0; kd = '0; kc = '0;
        nst = m_st; ntgt = m_tgt; ndir = m_dir;
        if (m_st == 3) begin
            an = m_up | m_dn | m_car;
            beyond = 0;
            for (int g = 0; g < NF; g++)
                if (an[g] && ((m_dir && g > m_tgt) || (!m_dir && g < m_tgt))) beyond = 1;
            kc[m_tgt] = 1'b1;
            if (m_dir || !beyond)  ku[m_tgt] = 1'b1;
            if (!m_dir || !beyond) kd[m_tgt] = 1'b1;
            ndir = beyond ? m_dir : !m_dir;
            m_sel(m_up & ~ku, m_dn & ~kd, m_car & ~kc, int'(cf_v), ndir, ok, fl, sd);
            if (ok) begin nst = 1; ntgt = fl; ndir = sd; end else nst = 0;
        end else if (m_st == 0) begin
            m_sel(m_up, m_dn, m_car, int'(cf_v), m_dir, ok, fl, sd);
            if (ok) begin nst = 1; ntgt = fl; ndir = sd; end
        end else if (m_st == 1) begin
            if (rdy_v) nst = 2;
        end else begin
            if (arr_v) nst = 3;
        end
        nu = (m_up  | (up_v & 8'h7F)) & ~ku;
        nd = (m_dn  | (dn_v & 8'hFE)) & ~kd;
        nc = (m_car | car_v)          & ~kc;
        if (!rst_v) begin
            nu = '0; nd = '0; nc = '0; nst = 0; ntgt = 0; ndir = 1;
        end
        @(posedge clk); #1;
        m_up = nu; m_dn = nd; m_car = nc; m_st = nst; m_tgt = ntgt; m_dir = ndir;
        chk("out", {tgt_valid_o, tgt_floor_o, dir_up_o}, {m_st == 1, 3'(m_tgt), m_dir});
        chk("pend", {pend_up_o, pend_dn_o, pend_car_o}, {m_up, m_dn, m_car});
        up_v = '0; dn_v = '0; car_v = '0; arr_v = 1'b0;
    endtask

    task automatic do_reset(input logic [2:0] cf);
        cf_v = cf; rdy_v = 1'b0; rst_v = 1'b0;
        tick(); tick();
        rst_v = 1'b1;
    endtask

    // Wait for an offer, accept it, travel one cycle and arrive; ends in CLEAR.
    task automatic serve(output int f);
        int n;
        n = 0;
        while (!tgt_valid_o && n < 40) begin tick(); n++; end
        chk("serve_vld", tgt_valid_o, 1'b1);
        f = int'(tgt_floor_o);
        rdy_v = 1'b1; tick(); rdy_v = 1'b0;
        tick();
        cf_v = 3'(f); arr_v = 1'b1; tick();
    endtask

    initial begin
        int f;
        bit moving;
        int dest, cnt;
        up_v = '0; dn_v = '0; car_v = '0; cf_v = '0; arr_v = 0; rdy_v = 0; rst_v = 0;
        m_up = '0; m_dn = '0; m_car = '0; m_st = 0; m_tgt = 0; m_dir = 1;
        @(posedge clk); #1;

        // 1: single car call, offered two cycles after the pulse
        do_reset(3'd0);
        chk("rst_out", {tgt_valid_o, tgt_floor_o, dir_up_o}, 5'b0_000_1);
        chk("rst_pend", {pend_up_o, pend_dn_o, pend_car_o}, 24'h0);
        car_v[5] = 1'b1; tick();
        chk("t1_early", tgt_valid_o, 1'b0);
        tick();
        chk("t1_offer", {tgt_valid_o, tgt_floor_o, dir_up_o}, 5'b1_101_1);
        serve(f); tick();
        chk("t1_car5", pend_car_o[5], 1'b0);
        chk("t1_idle", tgt_valid_o, 1'b0);

        // 2: sweep order 4, 6, then reverse to 1
        do_reset(3'd2);
        up_v[4] = 1'b1; dn_v[6] = 1'b1; car_v[1] = 1'b1; tick();
        serve(f); tick(); chk("t2_first", f, 4);
        serve(f); tick(); chk("t2_second", f, 6);
        chk("t2_dir", dir_up_o, 1'b0);
        serve(f); tick(); chk("t2_third", f, 1);

        // 3: nonexistent buttons are ignored
        do_reset(3'd3);
        dn_v[0] = 1'b1; up_v[7] = 1'b1; tick(); tick(); tick();
        chk("t3_pend", {pend_up_o, pend_dn_o, pend_car_o}, 24'h0);
        chk("t3_vld", tgt_valid_o, 1'b0);

        // 4: presses at the floor being cleared
        do_reset(3'd0);
        car_v[4] = 1'b1; car_v[6] = 1'b1; tick();
        serve(f);
        up_v[4] = 1'b1; dn_v[4] = 1'b1; tick();
        chk("t4_up4", pend_up_o[4], 1'b0);
        chk("t4_dn4", pend_dn_o[4], 1'b1);

        // 5: held offer is stable; arrive pulses in OFFER do nothing
        do_reset(3'd0);
        car_v[3] = 1'b1; tick(); tick();
        for (int i = 0; i < 10; i++) begin
            up_v = 8'($urandom); car_v = 8'($urandom); arr_v = i[0];
            tick();
            chk("t5_hold", {tgt_valid_o, tgt_floor_o}, 4'b1_011);
        end

        // 6: reset during travel drops everything
        do_reset(3'd0);
        car_v[2] = 1'b1; up_v[5] = 1'b1; dn_v[6] = 1'b1; tick(); tick();
        rdy_v = 1'b1; tick(); rdy_v = 1'b0; tick();
        rst_v = 1'b0; tick(); rst_v = 1'b1;
        chk("t6_out", {tgt_valid_o, tgt_floor_o, dir_up_o}, 5'b0_000_1);
        chk("t6_pend", {pend_up_o, pend_dn_o, pend_car_o}, 24'h0);

        // random traffic with a simple car that takes 1..4 cycles per trip
        do_reset(3'($urandom_range(0, 7)));
        moving = 0; dest = 0; cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            up_v  = ($urandom % 6 == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h0;
            dn_v  = ($urandom % 6 == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h0;
            car_v = ($urandom % 5 == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h0;
            rdy_v = 1'($urandom % 2);
            if (moving) begin
                cnt--;
                if (cnt == 0) begin arr_v = 1'b1; cf_v = 3'(dest); moving = 0; end
            end else if (tgt_valid_o && rdy_v) begin
                moving = 1; dest = int'(tgt_floor_o); cnt = $urandom_range(1, 4);
            end else if ($urandom % 8 == 0) begin
                arr_v = 1'b1;
            end
            if ($urandom % 500 == 0) begin rst_v = 1'b0; moving = 0; end
            else rst_v = 1'b1;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
